// File: rtl/age_ordered_issue_queue_if.sv
// Bundle of dispatch, wakeup, issue and flush signals for the age-ordered issue queue.
// The master side is the pipeline around the queue. The slave side is the queue itself.
interface age_ordered_issue_queue_if #(
    parameter int DEPTH      = 8,
    parameter int DISPATCH_W = 2,
    parameter int ISSUE_W    = 2,
    parameter int CDB_W      = 2,
    parameter int PRF_IDX    = 6,
    parameter int PAYLOAD_W  = 64
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                          flush;
    logic [DISPATCH_W-1:0]         dsp_valid;
    logic                          dsp_ready;
    logic [DISPATCH_W*PRF_IDX-1:0] dsp_rs1_phy;
    logic [DISPATCH_W-1:0]         dsp_rs1_rdy;
    logic [DISPATCH_W*PRF_IDX-1:0] dsp_rs2_phy;
    logic [DISPATCH_W-1:0]         dsp_rs2_rdy;
    logic [DISPATCH_W*PAYLOAD_W-1:0] dsp_payload;
    logic [CDB_W-1:0]              cdb_valid;
    logic [CDB_W*PRF_IDX-1:0]      cdb_rd_phy;
    logic [ISSUE_W-1:0]            iss_valid;
    logic [ISSUE_W-1:0]            iss_ready;
    logic [ISSUE_W*PRF_IDX-1:0]    iss_rs1_phy;
    logic [ISSUE_W*PRF_IDX-1:0]    iss_rs2_phy;
    logic [ISSUE_W*PAYLOAD_W-1:0]  iss_payload;
    logic [CW-1:0]                 occupancy;

    modport master (
        output flush, dsp_valid, dsp_rs1_phy, dsp_rs1_rdy, dsp_rs2_phy, dsp_rs2_rdy,
               dsp_payload, cdb_valid, cdb_rd_phy, iss_ready,
        input  dsp_ready, iss_valid, iss_rs1_phy, iss_rs2_phy, iss_payload, occupancy
    );

    modport slave (
        input  flush, dsp_valid, dsp_rs1_phy, dsp_rs1_rdy, dsp_rs2_phy, dsp_rs2_rdy,
               dsp_payload, cdb_valid, cdb_rd_phy, iss_ready,
        output dsp_ready, iss_valid, iss_rs1_phy, iss_rs2_phy, iss_payload, occupancy
    );
endinterface

// File: rtl/age_ordered_issue_queue.sv
// Collapsing age-ordered issue queue.
// Entry 0 is always the oldest entry, and the valid entries never have gaps between them.
// Each cycle the queue selects the ISSUE_W oldest ready entries and removes the ones that were accepted.
// It then packs the survivors down and appends the new dispatches after them.
module age_ordered_issue_queue #(
    parameter int DEPTH      = 8,
    parameter int DISPATCH_W = 2,
    parameter int ISSUE_W    = 2,
    parameter int CDB_W      = 2,
    parameter int PRF_IDX    = 6,
    parameter int PAYLOAD_W  = 64
) (
    input logic                      clk,
    input logic                      rst_n,
    age_ordered_issue_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PRF_IDX-1:0]   rs1_phy_reg [DEPTH];
    logic [PRF_IDX-1:0]   rs2_phy_reg [DEPTH];
    logic [PAYLOAD_W-1:0] payload_reg [DEPTH];
    logic [DEPTH-1:0]     rs1_rdy_reg;
    logic [DEPTH-1:0]     rs2_rdy_reg;
    logic [CW-1:0]        occ_reg;

    logic [PRF_IDX-1:0]   rs1_phy_next [DEPTH];
    logic [PRF_IDX-1:0]   rs2_phy_next [DEPTH];
    logic [PAYLOAD_W-1:0] payload_next [DEPTH];
    logic [DEPTH-1:0]     rs1_rdy_next;
    logic [DEPTH-1:0]     rs2_rdy_next;
    logic [CW-1:0]        occ_next;

    logic [DEPTH-1:0]     rs1_wake;
    logic [DEPTH-1:0]     rs2_wake;
    logic [DEPTH-1:0]     entry_rdy;
    logic [DEPTH-1:0]     depart;
    logic [IW-1:0]        sel_idx [ISSUE_W];
    logic [ISSUE_W-1:0]   sel_vld;
    logic                 dsp_rdy;

    // A tag is woken when any valid CDB lane carries it. Duplicate lanes just OR together.
    function automatic logic cdb_hit(input logic [PRF_IDX-1:0] tag,
                                     input logic [CDB_W-1:0] vld,
                                     input logic [CDB_W*PRF_IDX-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++) begin
            if (vld[c] && (tags[c*PRF_IDX +: PRF_IDX] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    // Dispatch acceptance depends on registered occupancy only. Slots freed by issue in the same cycle do not count.
    assign dsp_rdy       = !bus.flush && (occ_reg <= CW'(DEPTH - DISPATCH_W));
    assign bus.dsp_ready = dsp_rdy;
    assign bus.occupancy = occ_reg;

    // Source readiness includes the same-cycle CDB bypass. Flush masks every entry.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
        assign rs1_wake[gi]  = rs1_rdy_reg[gi] | cdb_hit(rs1_phy_reg[gi], bus.cdb_valid, bus.cdb_rd_phy);
        assign rs2_wake[gi]  = rs2_rdy_reg[gi] | cdb_hit(rs2_phy_reg[gi], bus.cdb_valid, bus.cdb_rd_phy);
        assign entry_rdy[gi] = !bus.flush && (CW'(gi) < occ_reg) && rs1_wake[gi] && rs2_wake[gi];
    end

    // Oldest-first select: port k gets the (k+1)-th ready entry, scanning upward from entry 0.
    always_comb begin
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            sel_idx[k] = '0;
            sel_vld[k] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_rdy[i] && (cnt < CW'(ISSUE_W))) begin
                for (int k = 0; k < ISSUE_W; k++) begin
                    if (cnt == CW'(k)) begin
                        sel_idx[k] = IW'(i);
                        sel_vld[k] = 1'b1;
                    end
                end
                cnt = cnt + 1'b1;
            end
        end
    end

    // Drive the issue ports from the selected entries.
    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_iss
        assign bus.iss_valid[gi]                              = sel_vld[gi];
        assign bus.iss_rs1_phy[gi*PRF_IDX +: PRF_IDX]         = rs1_phy_reg[sel_idx[gi]];
        assign bus.iss_rs2_phy[gi*PRF_IDX +: PRF_IDX]         = rs2_phy_reg[sel_idx[gi]];
        assign bus.iss_payload[gi*PAYLOAD_W +: PAYLOAD_W]     = payload_reg[sel_idx[gi]];
    end

    // An entry departs only when the port presenting it is accepted. A stalled port keeps its entry.
    always_comb begin
        depart = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < ISSUE_W; k++) begin
                if (sel_vld[k] && bus.iss_ready[k] && (sel_idx[k] == IW'(i))) depart[i] = 1'b1;
            end
        end
    end

    // Compaction: gather the survivors in age order, then append the fired dispatch lanes with no gaps.
    always_comb begin
        logic [CW-1:0] pos;
        pos          = '0;
        rs1_phy_next = rs1_phy_reg;
        rs2_phy_next = rs2_phy_reg;
        payload_next = payload_reg;
        rs1_rdy_next = rs1_rdy_reg;
        rs2_rdy_next = rs2_rdy_reg;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < occ_reg) && !depart[i]) begin
                rs1_phy_next[pos[IW-1:0]] = rs1_phy_reg[i];
                rs2_phy_next[pos[IW-1:0]] = rs2_phy_reg[i];
                payload_next[pos[IW-1:0]] = payload_reg[i];
                rs1_rdy_next[pos[IW-1:0]] = rs1_wake[i];
                rs2_rdy_next[pos[IW-1:0]] = rs2_wake[i];
                pos = pos + 1'b1;
            end
        end
        for (int l = 0; l < DISPATCH_W; l++) begin
            if (bus.dsp_valid[l] && dsp_rdy) begin
                rs1_phy_next[pos[IW-1:0]] = bus.dsp_rs1_phy[l*PRF_IDX +: PRF_IDX];
                rs2_phy_next[pos[IW-1:0]] = bus.dsp_rs2_phy[l*PRF_IDX +: PRF_IDX];
                payload_next[pos[IW-1:0]] = bus.dsp_payload[l*PAYLOAD_W +: PAYLOAD_W];
                rs1_rdy_next[pos[IW-1:0]] = bus.dsp_rs1_rdy[l] |
                    cdb_hit(bus.dsp_rs1_phy[l*PRF_IDX +: PRF_IDX], bus.cdb_valid, bus.cdb_rd_phy);
                rs2_rdy_next[pos[IW-1:0]] = bus.dsp_rs2_rdy[l] |
                    cdb_hit(bus.dsp_rs2_phy[l*PRF_IDX +: PRF_IDX], bus.cdb_valid, bus.cdb_rd_phy);
                pos = pos + 1'b1;
            end
        end
        occ_next = pos;
    end

    // State register. Flush empties the queue. Entry contents are left as-is because occupancy marks them invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_reg     <= '0;
            rs1_rdy_reg <= '0;
            rs2_rdy_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rs1_phy_reg[i] <= '0;
                rs2_phy_reg[i] <= '0;
                payload_reg[i] <= '0;
            end
        end else begin
            occ_reg     <= bus.flush ? '0 : occ_next;
            rs1_phy_reg <= rs1_phy_next;
            rs2_phy_reg <= rs2_phy_next;
            payload_reg <= payload_next;
            rs1_rdy_reg <= rs1_rdy_next;
            rs2_rdy_reg <= rs2_rdy_next;
        end
    end
endmodule
